tiny16_timer_irq: RTL and testbench

//   Memory-mapped down-counting timer with interrupt request, attached to the tiny16 CPU data bus.
//   It answers mem_valid/mem_ready bus cycles and drives the CPU interrupt input.

---
 rtl/tiny16_timer_irq_if.sv | 31 +++
 rtl/tiny16_timer_irq.sv | 148 ++++++++++++++
 tb/tb_tiny16_timer_irq.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tiny16_timer_irq_if.sv
// tiny16 data-bus bundle seen by the memory-mapped timer.
// The CPU side is master; the timer window is slave.
interface tiny16_timer_irq_if;
    logic [15:0] address;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        nwr;
    logic        mem_valid;
    logic        mem_ready;
    logic        selected;

    modport master (
        output address,
        output data_in,
        output nwr,
        output mem_valid,
        input  data_out,
        input  mem_ready,
        input  selected
    );

    modport slave (
        input  address,
        input  data_in,
        input  nwr,
        input  mem_valid,
        output data_out,
        output mem_ready,
        output selected
    );
endinterface

// File: rtl/tiny16_timer_irq.sv
// Programmable down-counting timer with interrupt request on the tiny16 bus.
// Four-word register window: CTRL, RELOAD, COUNT, STATUS.
module tiny16_timer_irq #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic              clk,
    input  logic              nreset,
    tiny16_timer_irq_if.slave bus,
    output logic              interrupt,
    input  logic              in_interrupt
);

    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        WAIT
    } state_t;

    state_t      state;
    logic        en;
    logic        irq_en;
    logic        auto_reload;
    logic        pending;
    logic [15:0] reload;
    logic [15:0] count;
    logic [15:0] prescaler;
    logic [15:0] rd_data;
    logic        hit;
    logic        wr;
    logic        wr_ctrl;
    logic        wr_reload;
    logic        wr_count;
    logic        wr_status;
    logic        tick;
    logic        expire;

    assign hit          = bus.mem_valid &&
                          (bus.address[15:2] == BASE_ADDR[15:2]);
    assign bus.selected = hit;

    // Writes commit only on the IDLE->ACK edge, so a held request cannot repeat.
    assign wr        = (state == IDLE) && hit && !bus.nwr;
    assign wr_ctrl   = wr && (bus.address[1:0] == 2'd0);
    assign wr_reload = wr && (bus.address[1:0] == 2'd1);
    assign wr_count  = wr && (bus.address[1:0] == 2'd2);
    assign wr_status = wr && (bus.address[1:0] == 2'd3);

    assign tick   = en && (prescaler == PS_MAX);
    assign expire = tick && (count == 16'd0);

    always_comb begin
        rd_data = '0;
        unique case (bus.address[1:0])
            2'd0: rd_data = {13'd0, auto_reload, irq_en, en};
            2'd1: rd_data = reload;
            2'd2: rd_data = count;
            2'd3: rd_data = {15'd0, pending};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state         <= IDLE;
            bus.mem_ready <= 1'b0;
            bus.data_out  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (hit) begin
                        state         <= ACK;
                        bus.mem_ready <= 1'b1;
                        bus.data_out  <= bus.nwr ? rd_data : 16'd0;
                    end
                end
                ACK: begin
                    state         <= WAIT;
                    bus.mem_ready <= 1'b0;
                    bus.data_out  <= '0;
                end
                WAIT: begin
                    if (!bus.mem_valid) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.mem_ready <= 1'b0;
                    bus.data_out  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            en          <= 1'b0;
            irq_en      <= 1'b0;
            auto_reload <= 1'b0;
            reload      <= '0;
            count       <= '0;
            pending     <= 1'b0;
            prescaler   <= '0;
            interrupt   <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                en          <= bus.data_in[0];
                irq_en      <= bus.data_in[1];
                auto_reload <= bus.data_in[2];
            end else if (expire && !auto_reload) begin
                en <= 1'b0;
            end

            if (wr_reload) begin
                reload <= bus.data_in;
            end

            if (wr_count) begin
                count <= bus.data_in;
            end else if (tick) begin
                if (count != 16'd0) begin
                    count <= count - 16'd1;
                end else if (auto_reload) begin
                    count <= reload;
                end
            end

            // An expiry on the same edge outranks both clear sources.
            if (expire) begin
                pending <= 1'b1;
            end else if (in_interrupt || (wr_status && bus.data_in[0])) begin
                pending <= 1'b0;
            end

            if (!en || wr_count || tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + 16'd1;
            end

            interrupt <= pending && irq_en && !in_interrupt;
        end
    end

endmodule

// File: tb/tb_tiny16_timer_irq.sv
// Directed bench for the tiny16 timer: bus handshake, periodic and
// one-shot expiry, acknowledge, same-edge collisions and address decode.
module tb_tiny16_timer_irq;

    logic clk;
    logic nreset;
    logic interrupt;
    logic in_interrupt;

    int n_checks;
    int n_fail;

    tiny16_timer_irq_if bus ();

    tiny16_timer_irq #(
        .BASE_ADDR(16'hFF00),
        .PRESCALE (1)
    ) dut (
        .clk         (clk),
        .nreset      (nreset),
        .bus         (bus.slave),
        .interrupt   (interrupt),
        .in_interrupt(in_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_xfer(input  logic [15:0] addr,
                            input  logic        wr,
                            input  logic [15:0] wdata,
                            output logic [15:0] rdata,
                            output int          lat);
        logic got;
        got   = 1'b0;
        rdata = '0;
        lat   = 0;
        @(negedge clk);
        bus.address   = addr;
        bus.data_in   = wdata;
        bus.nwr       = !wr;
        bus.mem_valid = 1'b1;
        while (!got && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.mem_ready) begin
                got   = 1'b1;
                rdata = bus.data_out;
            end
        end
        check("bus_ack", {31'd0, got}, 32'd1);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.nwr       = 1'b1;
        @(posedge clk);
        @(posedge clk);
    endtask

    task automatic wr_reg(input logic [1:0] off, input logic [15:0] d);
        logic [15:0] rd;
        int          lat;
        bus_xfer({14'h3FC0, off}, 1'b1, d, rd, lat);
    endtask

    task automatic rd_reg(input logic [1:0] off, output logic [15:0] d);
        int lat;
        bus_xfer({14'h3FC0, off}, 1'b0, 16'h0, d, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        int          lat;
        int          n;
        int          acks;

        n_checks      = 0;
        n_fail        = 0;
        nreset        = 1'b0;
        in_interrupt  = 1'b0;
        bus.address   = 16'hFF00;
        bus.data_in   = 16'h0;
        bus.nwr       = 1'b1;
        bus.mem_valid = 1'b1;

        // Reset held with a live in-window request.
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
        check("rst_irq", {31'd0, interrupt}, 32'd0);
        check("rst_dout", {16'd0, bus.data_out}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_newreq", {31'd0, bus.mem_ready}, 32'd1);
        check("rst_ctrl0", {16'd0, bus.data_out}, 32'd0);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Bus write/read and latency.
        wr_reg(2'd1, 16'h1234);
        bus_xfer(16'hFF01, 1'b0, 16'h0, rd, lat);
        check("rd_reload", {16'd0, rd}, 32'h1234);
        check("rd_latency", lat, 1);

        // Held request acked once.
        @(negedge clk);
        bus.address   = 16'hFF01;
        bus.nwr       = 1'b1;
        bus.mem_valid = 1'b1;
        acks = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) acks++;
        end
        check("hold_acks", acks, 1);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Periodic mode, 4-cycle period.
        wr_reg(2'd1, 16'd3);
        wr_reg(2'd2, 16'd3);
        wr_reg(2'd0, 16'h0007);
        n = 0;
        while (!interrupt && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("irq_first", {31'd0, interrupt}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            in_interrupt = 1'b1;
            @(posedge clk);
            #1;
            check("ack_low", {31'd0, interrupt}, 32'd0);
            @(negedge clk);
            in_interrupt = 1'b0;
            @(posedge clk);
            #1;
            check("ack_pend_clr", {31'd0, interrupt}, 32'd0);
            n = 2;
            while (!interrupt && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("irq_period", n, 4);
        end
        wr_reg(2'd0, 16'h0000);
        wr_reg(2'd3, 16'h0001);

        // One-shot after three ticks.
        wr_reg(2'd2, 16'd2);
        wr_reg(2'd0, 16'h0003);
        n = 0;
        while (!interrupt && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("oneshot_lat", n, 2);
        rd_reg(2'd0, rd);
        check("oneshot_ctrl", {16'd0, rd}, 32'h0002);
        rd_reg(2'd2, rd);
        check("oneshot_count", {16'd0, rd}, 32'h0000);
        rd_reg(2'd3, rd);
        check("oneshot_pend", {16'd0, rd}, 32'h0001);
        @(negedge clk);
        in_interrupt = 1'b1;
        @(negedge clk);
        in_interrupt = 1'b0;
        acks = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (interrupt) acks++;
        end
        check("oneshot_single", acks, 0);
        rd_reg(2'd3, rd);
        check("ack_status", {16'd0, rd}, 32'h0000);

        // STATUS clear on the expiry edge loses.
        wr_reg(2'd2, 16'd2);
        wr_reg(2'd0, 16'h0001);
        wr_reg(2'd3, 16'h0001);
        rd_reg(2'd3, rd);
        check("coll_status", {16'd0, rd}, 32'h0001);
        wr_reg(2'd3, 16'h0001);
        rd_reg(2'd3, rd);
        check("status_clr", {16'd0, rd}, 32'h0000);

        // COUNT write on a tick edge wins over the decrement.
        wr_reg(2'd2, 16'h1000);
        wr_reg(2'd0, 16'h0005);
        wr_reg(2'd2, 16'h0050);
        rd_reg(2'd2, rd);
        check("coll_count", {16'd0, rd}, 32'h004E);
        wr_reg(2'd0, 16'h0000);

        // Out-of-window access is ignored.
        @(negedge clk);
        bus.address   = 16'hFF04;
        bus.data_in   = 16'hBEEF;
        bus.nwr       = 1'b0;
        bus.mem_valid = 1'b1;
        #1;
        check("dec_sel", {31'd0, bus.selected}, 32'd0);
        acks = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.mem_ready) acks++;
        end
        check("dec_acks", acks, 0);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.nwr       = 1'b1;
        rd_reg(2'd0, rd);
        check("dec_ctrl", {16'd0, rd}, 32'h0000);
        rd_reg(2'd1, rd);
        check("dec_reload", {16'd0, rd}, 32'h0003);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
